// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N:1 multiplexer with clock-enable, output-valid
// strobe, out-of-range select detection with hold, and an auto-scan mode.
// The input at index k is a[k*WIDTH +: WIDTH]. y is updated one cycle after
// the enabled edge that sampled it.
//
// Optional build macro: MUX_N_REG_SCAN_DONE_EN
//   When defined, adds output scan_done. It is high for one cycle alongside
//   the y value taken from the last input during a scan.
module mux_n_reg #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        s,
    input  logic [N_IN*WIDTH-1:0]   a,
    output logic [WIDTH-1:0]        y,
    output logic                    y_valid,
    output logic [SEL_W-1:0]        sel_q,
    output logic                    sel_err
`ifdef MUX_N_REG_SCAN_DONE_EN
    ,
    output logic                    scan_done
`endif
);

    // N_IN may equal 2**SEL_W, so the range compare uses one extra bit.
    localparam logic [SEL_W:0]   NIN_EXT  = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] scan_q;
    logic [SEL_W-1:0] idx;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;

    // Pick the active index and qualify direct selects against N_IN.
    always_comb begin
        idx      = mode ? scan_q : s;
        in_range = ({1'b0, s} < NIN_EXT);
    end

    // Compare-based mux: an out-of-range index simply yields zero, so no
    // part-select ever goes past the end of a.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = a[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: update on enabled scan or in-range select, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            sel_q   <= '0;
            sel_err <= 1'b0;
        end else if (en) begin
            if (mode || in_range) begin
                y       <= sel_data;
                sel_q   <= idx;
                y_valid <= 1'b1;
                sel_err <= 1'b0;
            end else begin
                y_valid <= 1'b0;
                sel_err <= 1'b1;
            end
        end else begin
            y_valid <= 1'b0;
        end
    end

    // Scan position: cleared whenever in direct mode, so every scan starts at 0.
    always_ff @(posedge clk) begin
        if (reset || !mode) begin
            scan_q <= '0;
        end else if (en) begin
            scan_q <= (scan_q == LAST_IDX) ? '0 : scan_q + 1'b1;
        end
    end

`ifdef MUX_N_REG_SCAN_DONE_EN
    // End-of-scan strobe, aligned with the y value taken from the last input.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_done <= 1'b0;
        end else begin
            scan_done <= en && mode && (scan_q == LAST_IDX);
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed testbench for mux_n_reg. Three instances share clk, reset and
// the control inputs: N_IN=8 (SEL_W=3), N_IN=6 (SEL_W=3) and N_IN=5 (SEL_W=3).
// Input k of each instance carries a fixed base value plus k:
// 8'h10+k for N_IN=8, 8'h20+k for N_IN=6, and 8'h30+k for N_IN=5.
module tb_mux_n_reg;

    logic        clk = 1'b0;
    logic        reset, en, mode;
    logic [2:0]  s;
    logic [63:0] a8;
    logic [47:0] a6;
    logic [39:0] a5;

    logic [7:0]  y8, y6, y5;
    logic        v8, v6, v5;
    logic [2:0]  sq8, sq6, sq5;
    logic        e8, e6, e5;
`ifdef MUX_N_REG_SCAN_DONE_EN
    logic        sd8, sd6, sd5;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(8), .N_IN(8), .SEL_W(3)) u_d8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .a(a8),
        .y(y8), .y_valid(v8), .sel_q(sq8), .sel_err(e8)
`ifdef MUX_N_REG_SCAN_DONE_EN
        , .scan_done(sd8)
`endif
    );

    mux_n_reg #(.WIDTH(8), .N_IN(6), .SEL_W(3)) u_d6 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .a(a6),
        .y(y6), .y_valid(v6), .sel_q(sq6), .sel_err(e6)
`ifdef MUX_N_REG_SCAN_DONE_EN
        , .scan_done(sd6)
`endif
    );

    mux_n_reg #(.WIDTH(8), .N_IN(5), .SEL_W(3)) u_d5 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .a(a5),
        .y(y5), .y_valid(v5), .sel_q(sq5), .sel_err(e5)
`ifdef MUX_N_REG_SCAN_DONE_EN
        , .scan_done(sd5)
`endif
    );

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 1'b1; s = 3'd4;
        step(); step();
        total++; if (y8 !== 8'h00) $display("FAIL reset_y got=%h exp=00", y8); else passed++;
        total++; if (v8 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", v8); else passed++;
        total++; if (sq8 !== 3'd0) $display("FAIL reset_sel_q got=%0d exp=0", sq8); else passed++;
        total++; if (e8 !== 1'b0) $display("FAIL reset_sel_err got=%b exp=0", e8); else passed++;
        total++; if (y5 !== 8'h00) $display("FAIL reset_y5 got=%h exp=00", y5); else passed++;
`ifdef MUX_N_REG_SCAN_DONE_EN
        total++; if (sd5 !== 1'b0) $display("FAIL reset_scan_done got=%b exp=0", sd5); else passed++;
`endif
        reset = 1'b0;
        step();
        total++; if (y8 !== 8'h10) $display("FAIL reset_first_scan_y got=%h exp=10", y8); else passed++;
        total++; if (sq8 !== 3'd0) $display("FAIL reset_first_scan_sel got=%0d exp=0", sq8); else passed++;
        total++; if (v8 !== 1'b1) $display("FAIL reset_first_scan_valid got=%b exp=1", v8); else passed++;
    endtask

    task automatic test_direct();
        mode = 1'b0; en = 1'b1; s = 3'd5;
        step();
        total++; if (y8 !== 8'h15) $display("FAIL direct_y got=%h exp=15", y8); else passed++;
        total++; if (sq8 !== 3'd5) $display("FAIL direct_sel_q got=%0d exp=5", sq8); else passed++;
        total++; if (v8 !== 1'b1) $display("FAIL direct_valid got=%b exp=1", v8); else passed++;
        total++; if (e8 !== 1'b0) $display("FAIL direct_sel_err got=%b exp=0", e8); else passed++;
        en = 1'b0; s = 3'd1;
        step();
        total++; if (y8 !== 8'h15) $display("FAIL en0_hold_y got=%h exp=15", y8); else passed++;
        total++; if (v8 !== 1'b0) $display("FAIL en0_valid got=%b exp=0", v8); else passed++;
        total++; if (sq8 !== 3'd5) $display("FAIL en0_hold_sel got=%0d exp=5", sq8); else passed++;
        en = 1'b1; s = 3'd7;
        step();
        total++; if (y8 !== 8'h17) $display("FAIL direct_top_y got=%h exp=17", y8); else passed++;
        total++; if (e8 !== 1'b0) $display("FAIL direct_top_err got=%b exp=0", e8); else passed++;
        // Changing a right before the edge: the new value must be captured.
        s = 3'd3; a8[3*8 +: 8] = 8'hA5;
        step();
        total++; if (y8 !== 8'hA5) $display("FAIL direct_newdata_y got=%h exp=a5", y8); else passed++;
        a8[3*8 +: 8] = 8'h13;
`ifdef MUX_N_REG_SCAN_DONE_EN
        total++; if (sd8 !== 1'b0) $display("FAIL direct_scan_done got=%b exp=0", sd8); else passed++;
`endif
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; en = 1'b1; s = 3'd2;
        step();
        total++; if (y6 !== 8'h22) $display("FAIL oor_load_y got=%h exp=22", y6); else passed++;
        s = 3'd7;
        step();
        total++; if (y6 !== 8'h22) $display("FAIL oor7_y got=%h exp=22", y6); else passed++;
        total++; if (sq6 !== 3'd2) $display("FAIL oor7_sel_q got=%0d exp=2", sq6); else passed++;
        total++; if (e6 !== 1'b1) $display("FAIL oor7_err got=%b exp=1", e6); else passed++;
        total++; if (v6 !== 1'b0) $display("FAIL oor7_valid got=%b exp=0", v6); else passed++;
        s = 3'd6;
        step();
        total++; if (e6 !== 1'b1) $display("FAIL oor6_err got=%b exp=1", e6); else passed++;
        total++; if (y6 !== 8'h22) $display("FAIL oor6_y got=%h exp=22", y6); else passed++;
        en = 1'b0; s = 3'd0;
        step();
        total++; if (e6 !== 1'b1) $display("FAIL oor_en0_err_hold got=%b exp=1", e6); else passed++;
        en = 1'b1;
        step();
        total++; if (y6 !== 8'h20) $display("FAIL oor_clear_y got=%h exp=20", y6); else passed++;
        total++; if (e6 !== 1'b0) $display("FAIL oor_clear_err got=%b exp=0", e6); else passed++;
        total++; if (v6 !== 1'b1) $display("FAIL oor_clear_valid got=%b exp=1", v6); else passed++;
        s = 3'd5;
        step();
        total++; if (y6 !== 8'h25) $display("FAIL oor_edge5_y got=%h exp=25", y6); else passed++;
        total++; if (e6 !== 1'b0) $display("FAIL oor_edge5_err got=%b exp=0", e6); else passed++;
        s = 3'd6;
        step();
        mode = 1'b1;
        step();
        total++; if (e6 !== 1'b0) $display("FAIL oor_scan_clears_err got=%b exp=0", e6); else passed++;
        total++; if (y6 !== 8'h20) $display("FAIL oor_scan_y got=%h exp=20", y6); else passed++;
    endtask

    task automatic test_scan_wrap();
        logic [2:0] exp_sel;
        mode = 1'b0; en = 1'b1; s = 3'd0;
        step();
        mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_sel = 3'(i % 5);
            step();
            total++; if (sq5 !== exp_sel) $display("FAIL scan_wrap_sel[%0d] got=%0d exp=%0d", i, sq5, exp_sel); else passed++;
            total++; if (y5 !== 8'h30 + 8'(exp_sel)) $display("FAIL scan_wrap_y[%0d] got=%h exp=%h", i, y5, 8'h30 + 8'(exp_sel)); else passed++;
            total++; if (v5 !== 1'b1) $display("FAIL scan_wrap_valid[%0d] got=%b exp=1", i, v5); else passed++;
`ifdef MUX_N_REG_SCAN_DONE_EN
            total++; if (sd5 !== (exp_sel == 3'd4)) $display("FAIL scan_done[%0d] got=%b exp=%b", i, sd5, exp_sel == 3'd4); else passed++;
`endif
        end
    endtask

    task automatic test_pause_and_mode();
        mode = 1'b0; en = 1'b1;
        step();
        mode = 1'b1;
        step(); step(); step();
        total++; if (sq5 !== 3'd2) $display("FAIL pause_start_sel got=%0d exp=2", sq5); else passed++;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (sq5 !== 3'd2) $display("FAIL pause_sel[%0d] got=%0d exp=2", i, sq5); else passed++;
            total++; if (y5 !== 8'h32) $display("FAIL pause_y[%0d] got=%h exp=32", i, y5); else passed++;
            total++; if (v5 !== 1'b0) $display("FAIL pause_valid[%0d] got=%b exp=0", i, v5); else passed++;
        end
        en = 1'b1;
        step();
        total++; if (sq5 !== 3'd3) $display("FAIL resume_sel got=%0d exp=3", sq5); else passed++;
        total++; if (y5 !== 8'h33) $display("FAIL resume_y got=%h exp=33", y5); else passed++;
        mode = 1'b0; s = 3'd6;
        step();
        total++; if (e5 !== 1'b1) $display("FAIL switch_oor_err got=%b exp=1", e5); else passed++;
        total++; if (sq5 !== 3'd3) $display("FAIL switch_oor_sel got=%0d exp=3", sq5); else passed++;
        mode = 1'b1;
        step();
        total++; if (sq5 !== 3'd0) $display("FAIL rescan_sel got=%0d exp=0", sq5); else passed++;
        total++; if (y5 !== 8'h30) $display("FAIL rescan_y got=%h exp=30", y5); else passed++;
        total++; if (e5 !== 1'b0) $display("FAIL rescan_err got=%b exp=0", e5); else passed++;
    endtask

    task automatic test_reset_mid_scan();
        mode = 1'b0; en = 1'b1;
        step();
        mode = 1'b1;
        step(); step(); step(); step();
        total++; if (sq5 !== 3'd3) $display("FAIL midreset_pre_sel got=%0d exp=3", sq5); else passed++;
        reset = 1'b1;
        step();
        total++; if (y5 !== 8'h00) $display("FAIL midreset_y got=%h exp=00", y5); else passed++;
        total++; if (sq5 !== 3'd0) $display("FAIL midreset_sel got=%0d exp=0", sq5); else passed++;
        total++; if (v5 !== 1'b0) $display("FAIL midreset_valid got=%b exp=0", v5); else passed++;
        reset = 1'b0;
        step();
        total++; if (sq5 !== 3'd0) $display("FAIL postreset_sel got=%0d exp=0", sq5); else passed++;
        total++; if (y5 !== 8'h30) $display("FAIL postreset_y got=%h exp=30", y5); else passed++;
        step();
        total++; if (sq5 !== 3'd1) $display("FAIL postreset_next_sel got=%0d exp=1", sq5); else passed++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; s = 3'd0;
        for (int k = 0; k < 8; k++) a8[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 6; k++) a6[k*8 +: 8] = 8'h20 + 8'(k);
        for (int k = 0; k < 5; k++) a5[k*8 +: 8] = 8'h30 + 8'(k);
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan_wrap();
        test_pause_and_mode();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
Parametrised, registered N:1 multiplexer that generalises the combinational 8:1 datapath mux.
- Adds a clock-enable, an output-valid strobe, out-of-range select detection with hold, and an auto-scan mode.
- In scan mode the block steps through all inputs on its own; this is used to read out register banks sequentially in the multi-cycle datapath.
- Output is registered, so it can sit directly on a stage boundary.

Parameters:
- WIDTH, 8, data width of each input and of y.
- N_IN, 8, number of data inputs. Legal range is 2..2**SEL_W.
- SEL_W, 3, select width. Must satisfy 2**SEL_W >= N_IN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock-enable for the selection/update.
- mode  input  1  0 = direct select, 1 = auto-scan.
- s  input  SEL_W  select index; used only when mode=0.
- a  input  N_IN*WIDTH  packed inputs; input k occupies a[k*WIDTH +: WIDTH].
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y was updated on the last edge.
- sel_q  output  SEL_W  index that produced the current y.
- sel_err  output  1  the last enabled direct-mode select was out of range.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only at the rising edge of clk and has priority over all other inputs.
- Reset values: y=0, y_valid=0, sel_q=0, sel_err=0, internal scan counter scan_q=0.
- Latency: one cycle. Inputs sampled at edge k appear on y after edge k.
- en=0:
  - y, sel_q and sel_err hold.
  - y_valid <= 0.
  - scan_q holds.
- Direct mode (mode=0, en=1):
  - In range (s < N_IN): y <= a[s], sel_q <= s, y_valid <= 1, sel_err <= 0.
  - Out of range (s >= N_IN, possible only when N_IN < 2**SEL_W): y and sel_q hold, y_valid <= 0, sel_err <= 1.
  - scan_q is forced to 0 whenever mode=0, independent of en.
- Scan mode (mode=1, en=1):
  - y <= a[scan_q], sel_q <= scan_q, y_valid <= 1, sel_err <= 0.
  - scan_q <= (scan_q == N_IN-1) ? 0 : scan_q+1.
  - s is ignored.
- Mode transitions:
  - 0->1: the first enabled scan cycle always selects input 0, because scan_q was held at 0.
  - 1->0 mid-scan: the scan position is discarded; re-entering scan restarts at 0.
- Scan mode with en=0: the scan pauses; the next enabled cycle resumes at the held scan_q.
- Wrap-around: scan_q never reaches N_IN; it wraps from N_IN-1 to 0 in the same enabled cycle that outputs a[N_IN-1].
- Reset during scan: all state returns to reset values at that edge; en/mode in that cycle are ignored.
- Input changes: a may change every cycle; only the value present at the enabled edge is captured.
- sel_err is sticky only until the next enabled update. It clears on any enabled in-range direct select or any enabled scan cycle; en=0 holds it.
- Coding rules:
  - No combinational path from any input to any output.
  - No latches.
  - No X on outputs after reset for any select value.

Optional Feature:
- Macro: MUX_N_REG_SCAN_DONE_EN.
- When defined, adds output port scan_done (1 bit, reset 0).
  - scan_done pulses high for exactly one cycle after the enabled scan edge that outputs a[N_IN-1], i.e. coincident with that y value.
  - Otherwise 0.
  - Forced 0 in direct mode and when en=0.
- When not defined, the port does not exist and no logic is generated; all other behaviour is identical.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with en=1, mode=1, a non-zero -> y=0, y_valid=0, sel_q=0, sel_err=0. First enabled scan edge after release outputs a[0].
2. Direct select, defaults (WIDTH=8, N_IN=8):
   - Stimulus: a[k]=8'h10+k; s=5, en=1.
   - Next cycle: y=8'h15, sel_q=5, y_valid=1.
   - Then drop en=0: y holds 8'h15, y_valid=0.
3. Out-of-range select, N_IN=6, SEL_W=3:
   - Load s=2 -> y=a[2].
   - Then s=7, en=1 -> y stays a[2], sel_q=2, sel_err=1, y_valid=0.
   - Then s=0 -> y=a[0], sel_err=0.
4. Scan with wrap, N_IN=5:
   - mode=1, en=1 for 7 cycles -> sel_q sequence 0,1,2,3,4,0,1.
   - With MUX_N_REG_SCAN_DONE_EN: scan_done=1 only in the cycle sel_q=4.
5. Scan pause and mode switch:
   - Scan to sel_q=2, en=0 for 3 cycles -> y, sel_q hold, y_valid=0.
   - en=1 -> sel_q=3.
   - mode=0 one cycle with s=6, then mode=1 -> next scan output sel_q=0.
6. Reset mid-scan: assert reset at sel_q=3 -> all outputs 0 after that edge; next scan output sel_q=0.
